// File: rtl/control_estados.sv
// Game-flow controller for the hero game: power/greeting/selection/game states,
// button debouncing and the four 7-segment patterns for the display mux.
module control_estados #(
  parameter int HOLA_CYCLES     = 54_000_000,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       encendido,
  input  logic       cambio,
  input  logic       elegir,
  output logic [3:0] presente,
  output logic [6:0] display_a,
  output logic [6:0] display_b,
  output logic [6:0] display_c,
  output logic [6:0] display_d,
  output logic [1:0] personaje_sel
);

  localparam int TW = (HOLA_CYCLES > 1) ? $clog2(HOLA_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TW-1:0] HOLA_LAST = TW'(HOLA_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] APAGADO   = 2'd0;
  localparam logic [1:0] HOLA      = 2'd1;
  localparam logic [1:0] PERSONAJE = 2'd2;
  localparam logic [1:0] JUEGO     = 2'd3;

  localparam logic [6:0] SEG_H  = 7'b1110110;
  localparam logic [6:0] SEG_O  = 7'b0111111;
  localparam logic [6:0] SEG_L  = 7'b0111000;
  localparam logic [6:0] SEG_A  = 7'b1110111;
  localparam logic [6:0] SEG_P  = 7'b1110011;
  localparam logic [6:0] SEG_D1 = 7'b0000110;
  localparam logic [6:0] SEG_D2 = 7'b1011011;
  localparam logic [6:0] SEG_D3 = 7'b1001111;
  localparam logic [6:0] SEG_D4 = 7'b1100110;

  logic          enc_s1;
  logic          enc_s2;
  logic [1:0]    btn_raw;
  logic [1:0]    btn_s1;
  logic [1:0]    btn_s2;
  logic [1:0]    btn_acc;
  logic [1:0]    pulse;
  logic [DW-1:0] cnt [2];

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [1:0]    sel;
  logic [1:0]    sel_n;
  logic [6:0]    digit_n;
  logic [6:0]    da_n;
  logic [6:0]    db_n;
  logic [6:0]    dc_n;
  logic [6:0]    dd_n;

  // bit 0 = cambio, bit 1 = elegir
  assign btn_raw = {elegir, cambio};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_s1 <= 1'b0;
      enc_s2 <= 1'b0;
    end else begin
      enc_s1 <= encendido;
      enc_s2 <= enc_s1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_acc <= '0;
      pulse   <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (btn_s2[i] != btn_acc[i]) begin
          if (cnt[i] == DEB_LAST) begin
            btn_acc[i] <= btn_s2[i];
            pulse[i]   <= btn_s2[i];
            cnt[i]     <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    sel_n   = sel;
    if (!enc_s2) begin
      state_n = APAGADO;
      timer_n = '0;
      sel_n   = 2'd0;
    end else begin
      unique case (state)
        APAGADO: begin
          state_n = HOLA;
          timer_n = '0;
        end
        HOLA: begin
          if (timer == HOLA_LAST) begin
            state_n = PERSONAJE;
            sel_n   = 2'd0;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        PERSONAJE: begin
          if (pulse[1]) state_n = JUEGO;
          else if (pulse[0]) sel_n = sel + 2'd1;
        end
        JUEGO: state_n = JUEGO;
      endcase
    end
  end

  always_comb begin
    unique case (sel_n)
      2'd0: digit_n = SEG_D1;
      2'd1: digit_n = SEG_D2;
      2'd2: digit_n = SEG_D3;
      2'd3: digit_n = SEG_D4;
    endcase
  end

  always_comb begin
    da_n = 7'd0;
    db_n = 7'd0;
    dc_n = 7'd0;
    dd_n = 7'd0;
    unique case (state_n)
      HOLA: begin
        dd_n = SEG_H;
        dc_n = SEG_O;
        db_n = SEG_L;
        da_n = SEG_A;
      end
      PERSONAJE: begin
        dd_n = SEG_P;
        da_n = digit_n;
      end
      APAGADO, JUEGO: begin
        da_n = 7'd0;
      end
    endcase
  end

  // Displays are derived from the next state so they change with presente
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= APAGADO;
      timer     <= '0;
      sel       <= 2'd0;
      display_a <= 7'd0;
      display_b <= 7'd0;
      display_c <= 7'd0;
      display_d <= 7'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      sel       <= sel_n;
      display_a <= da_n;
      display_b <= db_n;
      display_c <= dc_n;
      display_d <= dd_n;
    end
  end

  assign presente      = {2'b00, state};
  assign personaje_sel = sel;

endmodule

// File: tb/tb_control_estados.sv
// Randomized and directed bench for control_estados against a behavioural
// model of the game flow, with literal checks on key scenarios.
module tb_control_estados;

  localparam int HOLA = 20;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       encendido = 1'b0;
  logic       cambio = 1'b0;
  logic       elegir = 1'b0;
  logic [3:0] presente;
  logic [6:0] display_a;
  logic [6:0] display_b;
  logic [6:0] display_c;
  logic [6:0] display_d;
  logic [1:0] personaje_sel;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  control_estados #(
    .HOLA_CYCLES(HOLA),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .encendido(encendido),
    .cambio(cambio),
    .elegir(elegir),
    .presente(presente),
    .display_a(display_a),
    .display_b(display_b),
    .display_c(display_c),
    .display_d(display_d),
    .personaje_sel(personaje_sel)
  );

  // Model: enc delayed 2 cycles; a button level is taken once the synced
  // input has disagreed with the accepted one for DEB consecutive cycles.
  int m_e1, m_e2;
  int m_b1[2], m_b2[2], m_acc[2], m_run[2], m_pul[2];
  int m_mode, m_tmr, m_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e1 <= 0; m_e2 <= 0;
      m_mode <= 0; m_tmr <= 0; m_sel <= 0;
      for (int i = 0; i < 2; i++) begin
        m_b1[i] <= 0; m_b2[i] <= 0; m_acc[i] <= 0;
        m_run[i] <= 0; m_pul[i] <= 0;
      end
    end else begin
      m_e1 <= int'(encendido);
      m_e2 <= m_e1;
      m_b1[0] <= int'(cambio);
      m_b1[1] <= int'(elegir);
      for (int i = 0; i < 2; i++) begin
        m_b2[i] <= m_b1[i];
        m_pul[i] <= 0;
        if (m_b2[i] == m_acc[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 == DEB) begin
          m_acc[i] <= m_b2[i];
          m_run[i] <= 0;
          m_pul[i] <= m_b2[i];
        end else m_run[i] <= m_run[i] + 1;
      end
      if (m_e2 == 0) begin
        m_mode <= 0; m_tmr <= 0; m_sel <= 0;
      end else if (m_mode == 0) begin
        m_mode <= 1; m_tmr <= 0;
      end else if (m_mode == 1) begin
        if (m_tmr == HOLA - 1) begin
          m_mode <= 2; m_sel <= 0;
        end else m_tmr <= m_tmr + 1;
      end else if (m_mode == 2) begin
        if (m_pul[1] != 0) m_mode <= 3;
        else if (m_pul[0] != 0) m_sel <= (m_sel + 1) % 4;
      end
    end
  end

  function automatic logic [6:0] digit(int s);
    case (s)
      0: return 7'b0000110;
      1: return 7'b1011011;
      2: return 7'b1001111;
      default: return 7'b1100110;
    endcase
  endfunction

  function automatic logic [27:0] exp_disp(int mode, int s);
    if (mode == 1) return {7'b1110110, 7'b0111111, 7'b0111000, 7'b1110111};
    if (mode == 2) return {7'b1110011, 7'd0, 7'd0, digit(s)};
    return 28'd0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("presente", int'(presente), m_mode);
    chk("personaje_sel", int'(personaje_sel), m_sel);
    chk("displays", int'({display_d, display_c, display_b, display_a}),
        int'(exp_disp(m_mode, m_sel)));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      cmp_model();
    end
  endtask

  task automatic press(input logic c, input logic e, input int hold);
    cambio = c;
    elegir = e;
    tick(hold);
    cambio = 1'b0;
    elegir = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(2);
    chk("rst_presente", int'(presente), 0);
    chk("rst_disp", int'({display_d, display_c, display_b, display_a}), 0);
    chk("rst_sel", int'(personaje_sel), 0);
    rst_n = 1'b1;
    tick(2);

    // power-on: hola three edges after encendido, held 20 cycles
    encendido = 1'b1;
    tick(2);
    chk("pon_not_yet", int'(presente), 0);
    tick(1);
    chk("pon_hola", int'(presente), 1);
    chk("model_hola", m_mode, 1);
    chk("hola_d", int'(display_d), int'(7'b1110110));
    chk("hola_c", int'(display_c), int'(7'b0111111));
    chk("hola_b", int'(display_b), int'(7'b0111000));
    chk("hola_a", int'(display_a), int'(7'b1110111));
    tick(19);
    chk("hola_last", int'(presente), 1);
    tick(1);
    chk("pers_enter", int'(presente), 2);
    chk("pers_a0", int'(display_a), int'(7'b0000110));
    chk("pers_d", int'(display_d), int'(7'b1110011));

    // selection wrap 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      press(1'b1, 1'b0, 8);
      chk("wrap_sel", int'(personaje_sel), (k + 1) % 4);
      if (k == 0) chk("wrap_a1", int'(display_a), int'(7'b1011011));
      if (k == 3) chk("wrap_a4", int'(display_a), int'(7'b0000110));
    end
    chk("model_sel", m_sel, 1);

    // bounce rejection, then one long hold gives a single step
    cambio = 1'b1; tick(2);
    cambio = 1'b0; tick(1);
    cambio = 1'b1; tick(2);
    cambio = 1'b0; tick(8);
    chk("bounce_sel", int'(personaje_sel), 1);
    press(1'b1, 1'b0, 10);
    chk("hold_sel", int'(personaje_sel), 2);

    // confirm wins over simultaneous cambio
    press(1'b1, 1'b1, 8);
    chk("conf_presente", int'(presente), 3);
    chk("conf_sel", int'(personaje_sel), 2);
    chk("conf_disp", int'({display_d, display_c, display_b, display_a}), 0);
    press(1'b1, 1'b0, 8);
    chk("juego_sel", int'(personaje_sel), 2);
    chk("juego_stay", int'(presente), 3);

    // power-off in juego, then in hola
    encendido = 1'b0;
    tick(2);
    chk("off_wait", int'(presente), 3);
    tick(1);
    chk("off_juego", int'(presente), 0);
    chk("off_sel", int'(personaje_sel), 0);
    encendido = 1'b1;
    tick(3);
    chk("reon_hola", int'(presente), 1);
    tick(10);
    encendido = 1'b0;
    tick(3);
    chk("off_hola", int'(presente), 0);
    chk("off_disp", int'({display_d, display_c, display_b, display_a}), 0);
    encendido = 1'b1;
    tick(3);
    chk("reon2_hola", int'(presente), 1);
    tick(19);
    chk("reon2_last", int'(presente), 1);
    tick(1);
    chk("reon2_pers", int'(presente), 2);

    // async reset between edges
    press(1'b1, 1'b0, 8);
    chk("pre_rst_sel", int'(personaje_sel), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_presente", int'(presente), 0);
    chk("arst_sel", int'(personaje_sel), 0);
    chk("arst_disp", int'({display_d, display_c, display_b, display_a}), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("arst_restart", int'(presente), 1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) encendido = ~encendido;
      if ($urandom_range(0, 5) == 0) cambio = ~cambio;
      if ($urandom_range(0, 19) == 0) elegir = ~elegir;
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/control_estados.md
# control_estados

Game-flow controller for the hero game; sits directly upstream of the four-digit display multiplexer. It produces the `presente` state code (apagado/hola/personaje/juego) and the four 7-segment patterns `display_a`..`display_d` that the multiplexer shows. It also debounces the two player buttons, times the greeting screen, and latches the selected character for the game logic.

## Interface
Parameters:
- `HOLA_CYCLES`, default 54_000_000: clock cycles the "HOLA" screen is held (2 s at 27 MHz).
- `DEBOUNCE_CYCLES`, default 270_000: clock cycles a button level must be stable before it is accepted (10 ms at 27 MHz).

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: reset, asynchronous and active-low.
- `encendido` in 1: power switch, level, asynchronous to `clk`.
- `cambio` in 1: "next character" button, active-high, bouncy, asynchronous to `clk`.
- `elegir` in 1: "confirm" button, active-high, bouncy, asynchronous to `clk`.
- `presente` out 4: state code. 0 = apagado, 1 = hola, 2 = personaje, 3 = juego.
- `display_a` out 7: pattern for the rightmost digit.
- `display_b` out 7: pattern for the second digit from the right.
- `display_c` out 7: pattern for the third digit from the right.
- `display_d` out 7: pattern for the leftmost digit.
- `personaje_sel` out 2: selected character, 0..3.

## Operation
- **Segment encoding**, all outputs: bit6..bit0 = g f e d c b a; 1 = segment lit; 7'd0 = blank.
  - H = 7'b1110110, O = 7'b0111111, L = 7'b0111000, A = 7'b1110111, P = 7'b1110011.
  - Digits: 1 = 7'b0000110, 2 = 7'b1011011, 3 = 7'b1001111, 4 = 7'b1100110.
- **`encendido` input**: passes through a 2-flop synchronizer, no debounce.
- **Button inputs**: each passes through a 2-flop synchronizer, then a debouncer.
  - A counter runs while the synchronized level differs from the accepted level and clears when they are equal.
  - When the count reaches `DEBOUNCE_CYCLES-1` with the mismatch still present, the accepted level takes the new value.
  - A 0→1 change of the accepted level emits a one-cycle pulse. Holding the button never repeats the pulse.
- **State machine** (`encendido` low is checked first in every state):
  - **apagado**: all displays 0. Synchronized `encendido` = 1 → hola; the timer clears.
  - **hola**: display_d..a = H, O, L, A. The timer increments each cycle. At `HOLA_CYCLES-1` → personaje with `personaje_sel` = 0. Button pulses are ignored here.
  - **personaje**: display_d = P, display_c = display_b = 0, display_a = digit (`personaje_sel`+1).
    - A `cambio` pulse increments `personaje_sel`, wrapping from 3 to 0.
    - An `elegir` pulse → juego, and `personaje_sel` freezes.
    - If both pulses arrive in the same cycle, `elegir` wins and `personaje_sel` is unchanged.
  - **juego**: all displays 0 (the display stage supplies its own data). Buttons are ignored. This state has no exit except `encendido` low.
  - **Any state with synchronized `encendido` = 0** → apagado on the next edge. The timer and `personaje_sel` clear to 0.
- **Registered outputs**: `presente` and all display outputs are registered and are updated on the same edge, so they always agree.

## Timing
- **Reset values**: `presente` = 0, display_a..d = 0, `personaje_sel` = 0. Synchronizers, debouncer counters, accepted levels and the timer all clear.
- **Asynchronous reset mid-operation**: all outputs return to reset values immediately. On release, the block restarts from apagado. A button held through reset is accepted as a new press once stable for `DEBOUNCE_CYCLES`.
- **`encendido` latency**: `encendido` edge → `presente` change in 3 `clk` edges (2 synchronizer edges + 1 state edge).
- **Button latency**: a clean button rise → pulse after 2 + `DEBOUNCE_CYCLES` edges. State or `personaje_sel` updates 1 edge after the pulse.
- **Bounce rejection**: a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no pulse.
- **Hola duration**: `presente` = 1 for exactly `HOLA_CYCLES` cycles.
- **Timer width**: `$clog2(HOLA_CYCLES)` bits; it never wraps, because it stops on exit.

## Test plan
All scenarios use `HOLA_CYCLES` = 20 and `DEBOUNCE_CYCLES` = 4.
- **Power-on**: reset, then `encendido` = 1 → `presente` = 1 three edges later, display_d..a = 7'b1110110, 7'b0111111, 7'b0111000, 7'b1110111; after 20 cycles `presente` = 2, display_a = 7'b0000110.
- **Selection wrap**: in personaje, 5 clean `cambio` presses → `personaje_sel` sequence 1, 2, 3, 0, 1; display_a = 7'b1011011 after the first press and 7'b0000110 after the fourth.
- **Bounce**: `cambio` toggled high for 2 cycles, low for 1, high for 2, then low → `personaje_sel` unchanged. Then held high for 10 cycles → exactly one increment.
- **Confirm priority**: `cambio` and `elegir` rising together → `presente` = 3, `personaje_sel` unchanged, all displays 0. Further `cambio` presses → no change.
- **Power-off**: `encendido` dropped during hola and again during juego → `presente` = 0 three edges later, `personaje_sel` = 0, displays 0. Re-enabling restarts a full 20-cycle hola.
- **Async reset**: `rst_n` pulsed low mid-personaje, between clock edges → outputs 0 immediately, without waiting for an edge.
